// File: rtl/vga_timing_gen_if.sv
// Renderer and DAC signal bundle for the VGA raster master.
// master = timing generator, slave = renderer/DAC side.
interface vga_timing_gen_if;
    logic [23:0] color;
    logic        test_mode;
    logic [9:0]  x_curr;
    logic [8:0]  y_curr;
    logic        frame_start;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic        vga_clk;

    modport master (
        input  color, test_mode,
        output x_curr, y_curr, frame_start,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk
    );

    modport slave (
        output color, test_mode,
        input  x_curr, y_curr, frame_start,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster master: publishes clamped pixel coordinate, registers color/sync/blank one pixel later.
// No backpressure; optional colour-bar generator under VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - 1);

    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0] Y_MAX  = 9'(V_ACTIVE - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             pix_en;
    logic             run;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic [9:0]       x_pos;
    logic [8:0]       y_pos;
    logic [23:0]      pix_rgb;

    logic [23:0]      rgb_q;
    logic             hs_q;
    logic             vs_q;
    logic             blank_n_q;
    logic             vga_clk_q;

    always_comb begin
        pix_en = (div_cnt == DIV_LAST);
        div_nxt = pix_en ? '0 : div_cnt + 1'b1;
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        // Clamp so renderers never see coordinates outside the visible area
        x_pos = (h_cnt < H_ACT) ? h_cnt : X_MAX;
        y_pos = (v_cnt < V_ACT) ? v_cnt[8:0] : Y_MAX;
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [23:0] pat_rgb;

    always_comb begin
        bar = 3'(x_pos / 10'd80);
        pat_rgb = 24'h000000;
        case (bar)
            3'd0: pat_rgb = 24'hFFFFFF;
            3'd1: pat_rgb = 24'hFFFF00;
            3'd2: pat_rgb = 24'h00FFFF;
            3'd3: pat_rgb = 24'h00FF00;
            3'd4: pat_rgb = 24'hFF00FF;
            3'd5: pat_rgb = 24'hFF0000;
            3'd6: pat_rgb = 24'h0000FF;
            3'd7: pat_rgb = 24'h000000;
            default: pat_rgb = 24'h000000;
        endcase
        pix_rgb = vga.test_mode ? pat_rgb : vga.color;
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = vga.test_mode;
    assign pix_rgb = vga.color;
`endif

    // vga_clk is registered from the next divider value so it rises mid-pixel without glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            vga_clk_q <= (div_nxt >= DIV_HALF);
        end
    end

    // The first pix_en after reset only arms the raster; pixel (0,0) then lasts a full period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run   <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (!run) begin
                run <= 1'b1;
            end else if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_en) begin
            rgb_q     <= active ? pix_rgb : 24'h000000;
            hs_q      <= hs_raw;
            vs_q      <= vs_raw;
            blank_n_q <= active;
        end
    end

    assign vga.x_curr      = x_pos;
    assign vga.y_curr      = y_pos;
    assign vga.frame_start = pix_en && run && h_wrap && v_wrap;
    assign vga.vga_r       = rgb_q[23:16];
    assign vga.vga_g       = rgb_q[15:8];
    assign vga.vga_b       = rgb_q[7:0];
    assign vga.vga_hs      = hs_q;
    assign vga.vga_vs      = vs_q;
    assign vga.vga_blank_n = blank_n_q;
    assign vga.vga_sync_n  = 1'b0;
    assign vga.vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shortened vertical raster (17 lines) to keep frames short.
module tb_vga_timing_gen;

    localparam int CYC_PER_FRAME = 800 * 17 * 2;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [23:0] P0 = 24'hFFFFFF;
    localparam logic [23:0] P1 = 24'hFFFF00;
    localparam logic [23:0] P2 = 24'h00FFFF;
`else
    localparam logic [23:0] P0 = 24'h000000;
    localparam logic [23:0] P1 = 24'h000000;
    localparam logic [23:0] P2 = 24'h000000;
`endif
    localparam logic [23:0] P7 = 24'h000000;

    typedef struct {
        int          k;
        logic        tm;
        logic        cz;
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic cz    = 1'b0;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    vga_timing_gen_if bus();

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(bus)
    );

    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    // Renderer stand-in: echoes the coordinate it is shown
    always @* bus.color = cz ? 24'h000000 : {bus.x_curr[7:0], bus.y_curr[7:0], 8'hA5};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic to_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 200000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    function automatic void add(input int k, input logic tm, input logic z, input int x, input int y,
                                input logic [23:0] rgb, input logic hs, input logic vs, input logic bl);
        vec_t v;
        v.k = k; v.tm = tm; v.cz = z; v.ex = 10'(x); v.ey = 9'(y);
        v.rgb = rgb; v.hs = hs; v.vs = vs; v.bl = bl;
        vecs.push_back(v);
    endfunction

    function automatic logic [23:0] rgb_pins();
        return {bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    initial begin
        int f1, f2, hs_falls, hs_fall1, hs_fall2, hs_rise1, vs_fall, vs_rise;
        logic prev_hs, prev_vs;

        //   k      tm    cz    x    y   rgb          hs    vs    blank_n
        add(0,     1'b0, 1'b0, 0,   0,  24'h0000A5, 1'b1, 1'b1, 1'b1);
        add(639,   1'b0, 1'b0, 639, 0,  24'h7F00A5, 1'b1, 1'b1, 1'b1);
        add(640,   1'b0, 1'b0, 639, 0,  24'h000000, 1'b1, 1'b1, 1'b0);
        add(655,   1'b0, 1'b0, 639, 0,  24'h000000, 1'b1, 1'b1, 1'b0);
        add(656,   1'b0, 1'b0, 639, 0,  24'h000000, 1'b0, 1'b1, 1'b0);
        add(751,   1'b0, 1'b0, 639, 0,  24'h000000, 1'b0, 1'b1, 1'b0);
        add(752,   1'b0, 1'b0, 639, 0,  24'h000000, 1'b1, 1'b1, 1'b0);
        add(799,   1'b0, 1'b0, 639, 0,  24'h000000, 1'b1, 1'b1, 1'b0);
        add(800,   1'b0, 1'b0, 0,   1,  24'h0001A5, 1'b1, 1'b1, 1'b1);
        add(1600,  1'b1, 1'b1, 0,   2,  P0,         1'b1, 1'b1, 1'b1);
        add(1680,  1'b1, 1'b1, 80,  2,  P1,         1'b1, 1'b1, 1'b1);
        add(1760,  1'b1, 1'b1, 160, 2,  P2,         1'b1, 1'b1, 1'b1);
        add(2239,  1'b1, 1'b1, 639, 2,  P7,         1'b1, 1'b1, 1'b1);
        add(2240,  1'b1, 1'b1, 639, 2,  24'h000000, 1'b1, 1'b1, 1'b0);
        add(2400,  1'b0, 1'b0, 0,   3,  24'h0003A5, 1'b1, 1'b1, 1'b1);
        add(4123,  1'b0, 1'b0, 123, 5,  24'h7B05A5, 1'b1, 1'b1, 1'b1);
        add(8810,  1'b0, 1'b0, 10,  11, 24'h0A0BA5, 1'b1, 1'b1, 1'b1);
        add(9605,  1'b0, 1'b0, 5,   11, 24'h000000, 1'b1, 1'b1, 1'b0);
        add(11200, 1'b0, 1'b0, 0,   11, 24'h000000, 1'b1, 1'b0, 1'b0);
        add(11856, 1'b0, 1'b0, 639, 11, 24'h000000, 1'b0, 1'b0, 1'b0);
        add(12799, 1'b0, 1'b0, 639, 11, 24'h000000, 1'b1, 1'b0, 1'b0);
        add(12800, 1'b0, 1'b0, 0,   11, 24'h000000, 1'b1, 1'b1, 1'b0);

        bus.test_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs", bus.vga_hs, 1);
        chk("rst_vs", bus.vga_vs, 1);
        chk("rst_blank_n", bus.vga_blank_n, 0);
        chk("rst_rgb", rgb_pins(), 0);
        chk("rst_x", bus.x_curr, 0);
        chk("rst_y", bus.y_curr, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        chk("rst_vga_clk", bus.vga_clk, 0);
        chk("sync_n", bus.vga_sync_n, 0);

        // Mid-line asynchronous reset
        @(negedge clk) reset = 1'b1;
        to_cyc(2 + 2 * 300);
        chk("pre_rst_x", bus.x_curr, 300);
        chk("pre_rst_rgb", rgb_pins(), 24'h2B00A5);
        #2 reset = 1'b0;
        #1;
        chk("midrst_x", bus.x_curr, 0);
        chk("midrst_rgb", rgb_pins(), 0);
        chk("midrst_blank_n", bus.vga_blank_n, 0);
        chk("midrst_hs", bus.vga_hs, 1);
        chk("midrst_vs", bus.vga_vs, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        foreach (vecs[i]) begin
            to_cyc(2 + 2 * vecs[i].k);
            bus.test_mode = vecs[i].tm;
            cz = vecs[i].cz;
            chk($sformatf("x[%0d]", vecs[i].k), bus.x_curr, vecs[i].ex);
            chk($sformatf("y[%0d]", vecs[i].k), bus.y_curr, vecs[i].ey);
            to_cyc(4 + 2 * vecs[i].k);
            chk($sformatf("rgb[%0d]", vecs[i].k), rgb_pins(), vecs[i].rgb);
            chk($sformatf("hs[%0d]", vecs[i].k), bus.vga_hs, vecs[i].hs);
            chk($sformatf("vs[%0d]", vecs[i].k), bus.vga_vs, vecs[i].vs);
            chk($sformatf("blank_n[%0d]", vecs[i].k), bus.vga_blank_n, vecs[i].bl);
        end
        bus.test_mode = 1'b0;
        cz = 1'b0;

        // First pix_en is sampled at cyc 1; frame_start must follow exactly one frame later
        f1 = -1;
        while (f1 < 0 && cyc < 2 * CYC_PER_FRAME) begin
            @(posedge clk);
            #1;
            if (bus.frame_start) f1 = cyc;
        end
        chk("first_frame_start_cyc", f1, 1 + CYC_PER_FRAME);
        chk("vga_clk_late_half", bus.vga_clk, 1);

        f2 = -1; hs_falls = 0; hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
        vs_fall = -1; vs_rise = -1;
        prev_hs = bus.vga_hs;
        prev_vs = bus.vga_vs;
        while (f2 < 0 && f1 >= 0 && cyc < f1 + CYC_PER_FRAME + 100) begin
            @(posedge clk);
            #1;
            if (cyc == f1 + 1) begin
                chk("frame_start_width", bus.frame_start, 0);
                chk("vga_clk_early_half", bus.vga_clk, 0);
                chk("origin_x", bus.x_curr, 0);
                chk("origin_y", bus.y_curr, 0);
            end
            if (prev_hs && !bus.vga_hs) begin
                hs_falls++;
                if (hs_fall1 < 0) hs_fall1 = cyc;
                else if (hs_fall2 < 0) hs_fall2 = cyc;
            end
            if (!prev_hs && bus.vga_hs && hs_fall1 >= 0 && hs_rise1 < 0) hs_rise1 = cyc;
            if (prev_vs && !bus.vga_vs && vs_fall < 0) vs_fall = cyc;
            if (!prev_vs && bus.vga_vs && vs_fall >= 0 && vs_rise < 0) vs_rise = cyc;
            if (bus.frame_start) f2 = cyc;
            prev_hs = bus.vga_hs;
            prev_vs = bus.vga_vs;
        end
        chk("frame_period", f2 - f1, CYC_PER_FRAME);
        chk("hs_fall_pos", hs_fall1 - f1, 1 + 2 * 657);
        chk("hs_period", hs_fall2 - hs_fall1, 1600);
        chk("hs_low_width", hs_rise1 - hs_fall1, 192);
        chk("lines_per_frame", hs_falls, 17);
        chk("vs_fall_pos", vs_fall - f1, 1 + 2 * (14 * 800 + 1));
        chk("vs_low_width", vs_rise - vs_fall, 2 * 1600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
